// File: rtl/dsadc_pkg.sv
// Shared types for the dual-slope ADC sequencer: FSM state encoding and BCD digit type.
package dsadc_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        AUTOZERO    = 3'd1,
        INTEGRATE   = 3'd2,
        DEINTEGRATE = 3'd3,
        LATCH       = 3'd4
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_counter.sv
// NDIG-digit cascaded BCD counter with synchronous clear and count enable.
// all_nines flags the terminal count so the caller can use it as the carry-out.
module bcd_counter
    import dsadc_pkg::*;
#(
    parameter int NDIG = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    output logic [4*NDIG-1:0] count,
    output logic              all_nines
);

    logic [4*NDIG-1:0] next_count;
    logic              carry;

    // Ripple the increment upward: a digit advances only when every lower digit was 9.
    always_comb begin
        next_count = count;
        all_nines  = 1'b1;
        carry      = en;
        for (int d = 0; d < NDIG; d++) begin
            if (count[4*d +: 4] != BCD_MAX) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (count[4*d +: 4] == BCD_MAX) begin
                    next_count[4*d +: 4] = 4'd0;
                end else begin
                    next_count[4*d +: 4] = count[4*d +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            count <= next_count;
        end
    end

endmodule

// File: rtl/dual_slope_sequencer.sv
// Dual-slope integrating ADC sequencer: auto-zero, fixed integrate, de-integrate, latch.
// Optional DSADC_HOLD_EN adds a hold input that freezes the displayed result.
module dual_slope_sequencer
    import dsadc_pkg::*;
#(
    parameter int NDIG        = 3,
    parameter int T_AZ        = 100,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cont_mode,
    input  logic              cmp_zero,
    input  logic              polarity,
`ifdef DSADC_HOLD_EN
    input  logic              hold,
`endif
    output logic              sw_az,
    output logic              sw_vin,
    output logic              sw_vref,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] result_bcd,
    output logic              result_neg,
    output logic              overrange
);

    localparam int AZ_W = (T_AZ > 1) ? $clog2(T_AZ) : 1;

    state_t            state;
    state_t            next_state;
    logic              start_d;
    logic              start_rise;
    logic [SYNC_STAGES-1:0] zero_sync;
    logic [SYNC_STAGES-1:0] pol_sync;
    logic              cmp_sync;
    logic              pol_synced;
    logic [AZ_W-1:0]   az_cnt;
    logic              az_last;
    logic              cnt_clr;
    logic              cnt_en;
    logic              ovr_hit;
    logic              all_nines;
    logic [4*NDIG-1:0] count;
    logic              pol_q;
    logic              result_upd;

`ifdef DSADC_HOLD_EN
    assign result_upd = !hold;
`else
    assign result_upd = 1'b1;
`endif

    assign start_rise = start && !start_d;
    assign cmp_sync   = zero_sync[SYNC_STAGES-1];
    assign pol_synced = pol_sync[SYNC_STAGES-1];
    assign az_last    = (az_cnt == AZ_W'(T_AZ - 1));

    // Comparator outputs are asynchronous to clk; the added latency shows up as count overshoot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_sync <= '0;
            pol_sync  <= '0;
            start_d   <= 1'b0;
        end else begin
            zero_sync <= {zero_sync[SYNC_STAGES-2:0], cmp_zero};
            pol_sync  <= {pol_sync[SYNC_STAGES-2:0], polarity};
            start_d   <= start;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            az_cnt <= '0;
        end else if (state == AUTOZERO) begin
            az_cnt <= az_cnt + AZ_W'(1);
        end else begin
            az_cnt <= '0;
        end
    end

    bcd_counter #(
        .NDIG (NDIG)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .count     (count),
        .all_nines (all_nines)
    );

    // The counter's terminal count ends integrate; in de-integrate the zero crossing wins over it.
    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        ovr_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (start_rise || cont_mode) begin
                    next_state = AUTOZERO;
                    cnt_clr    = 1'b1;
                end
            end
            AUTOZERO: begin
                if (az_last) begin
                    next_state = INTEGRATE;
                end
            end
            INTEGRATE: begin
                cnt_en = 1'b1;
                if (all_nines) begin
                    next_state = DEINTEGRATE;
                end
            end
            DEINTEGRATE: begin
                if (cmp_sync) begin
                    next_state = LATCH;
                end else if (all_nines) begin
                    next_state = LATCH;
                    ovr_hit    = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            LATCH: begin
                if (cont_mode) begin
                    next_state = AUTOZERO;
                    cnt_clr    = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Switches, busy and done are registered from next_state so they line up with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sw_az   <= 1'b1;
            sw_vin  <= 1'b0;
            sw_vref <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pol_q   <= 1'b0;
        end else begin
            state   <= next_state;
            sw_az   <= (next_state == IDLE) || (next_state == AUTOZERO) || (next_state == LATCH);
            sw_vin  <= (next_state == INTEGRATE);
            sw_vref <= (next_state == DEINTEGRATE);
            busy    <= (next_state != IDLE);
            done    <= (next_state == LATCH);
            if (state == INTEGRATE && all_nines) begin
                pol_q <= pol_synced;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_bcd <= '0;
            result_neg <= 1'b0;
            overrange  <= 1'b0;
        end else if (state == DEINTEGRATE && next_state == LATCH && result_upd) begin
            result_bcd <= count;
            result_neg <= pol_q;
            overrange  <= ovr_hit;
        end
    end

endmodule

// File: tb/tb_dual_slope_sequencer.sv
// Self-checking bench for dual_slope_sequencer (NDIG=3, T_AZ=4, SYNC_STAGES=2).
// Build with DSADC_HOLD_EN defined to also exercise the hold input.
module tb_dual_slope_sequencer;

    localparam int NDIG        = 3;
    localparam int T_AZ        = 4;
    localparam int SYNC_STAGES = 2;
    localparam int FULL_SCALE  = 1000;

    logic        clk;
    logic        reset;
    logic        start;
    logic        cont_mode;
    logic        cmp_zero;
    logic        polarity;
`ifdef DSADC_HOLD_EN
    logic        hold;
`endif
    logic        sw_az;
    logic        sw_vin;
    logic        sw_vref;
    logic        busy;
    logic        done;
    logic [11:0] result_bcd;
    logic        result_neg;
    logic        overrange;

    int tests_run    = 0;
    int tests_failed = 0;
    int onehot_errs  = 0;

    typedef struct {
        int          zero_at;
        logic        pol;
        logic [11:0] exp_bcd;
        logic        exp_neg;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs[7];

    dual_slope_sequencer #(
        .NDIG        (NDIG),
        .T_AZ        (T_AZ),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cont_mode  (cont_mode),
        .cmp_zero   (cmp_zero),
        .polarity   (polarity),
`ifdef DSADC_HOLD_EN
        .hold       (hold),
`endif
        .sw_az      (sw_az),
        .sw_vin     (sw_vin),
        .sw_vref    (sw_vref),
        .busy       (busy),
        .done       (done),
        .result_bcd (result_bcd),
        .result_neg (result_neg),
        .overrange  (overrange)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (int'(sw_az) + int'(sw_vin) + int'(sw_vref) != 1) begin
            onehot_errs++;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference: the held count is the count at which the synchronized zero flag is first
    // seen; a count beyond full scale is reported as all nines with overrange.
    task automatic modelResult(input int zero_at, output int bcd, output int ovr);
        int v;
        if (zero_at < 0 || zero_at > FULL_SCALE - 1) begin
            v   = FULL_SCALE - 1;
            ovr = 1;
        end else begin
            v   = zero_at;
            ovr = 0;
        end
        bcd = ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endtask

    // zero_at = count at which the synchronized comparator is high (-1 = never).
    task automatic applyStimulus(input int zero_at, input logic pol, input bit use_start,
                                 input bit drop_cont, input bit extra_start,
                                 output int got_bcd, output int got_neg, output int got_ovr);
        int n;
        int vin;
        int i;
        int k;
        bit idle_seen;
        k         = (zero_at < 0) ? 100000 : zero_at - SYNC_STAGES;
        polarity  = pol;
        cmp_zero  = 1'b0;
        idle_seen = 1'b0;
        n         = 0;
        if (use_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n     = 1;
        end
        while (!sw_vin && n < 64) begin
            @(negedge clk);
            n++;
            if (!busy) idle_seen = 1'b1;
        end
        if (use_start) checkOutput("autozero_cycles", n - 1, T_AZ);
        if (drop_cont) cont_mode = 1'b0;
        vin = 0;
        while (sw_vin && vin < 1100) begin
            vin++;
            start = extra_start && (vin == 500);
            @(negedge clk);
            if (!busy) idle_seen = 1'b1;
        end
        start = 1'b0;
        checkOutput("integrate_cycles", vin, FULL_SCALE);
        checkOutput("sw_vref_on", int'(sw_vref), 1);
        i = 0;
        while (!done && i < 1100) begin
            if (i == k) cmp_zero = 1'b1;
            @(negedge clk);
            i++;
            if (!busy) idle_seen = 1'b1;
        end
        checkOutput("done_seen", int'(done), 1);
        checkOutput("busy_throughout", int'(idle_seen), 0);
        got_bcd  = int'(result_bcd);
        got_neg  = int'(result_neg);
        got_ovr  = int'(overrange);
        cmp_zero = 1'b0;
        @(negedge clk);
        checkOutput("done_width", int'(done), 0);
        if (!cont_mode) checkOutput("idle_after", int'(busy), 0);
    endtask

    initial begin
        int gb;
        int gn;
        int go;
        int eb;
        int eo;
        int za;
        logic pl;

        vecs[0] = '{437,  1'b0, 12'h437, 1'b0, 1'b0};
        vecs[1] = '{52,   1'b1, 12'h052, 1'b1, 1'b0};
        vecs[2] = '{-1,   1'b0, 12'h999, 1'b0, 1'b1};
        vecs[3] = '{250,  1'b0, 12'h250, 1'b0, 1'b0};
        vecs[4] = '{999,  1'b1, 12'h999, 1'b1, 1'b0};
        vecs[5] = '{2,    1'b0, 12'h002, 1'b0, 1'b0};
        vecs[6] = '{1000, 1'b0, 12'h999, 1'b0, 1'b1};

        reset     = 1'b0;
        start     = 1'b0;
        cont_mode = 1'b0;
        cmp_zero  = 1'b0;
        polarity  = 1'b0;
`ifdef DSADC_HOLD_EN
        hold      = 1'b0;
`endif
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_sw_az", int'(sw_az), 1);
        checkOutput("rst_sw_vin", int'(sw_vin), 0);
        checkOutput("rst_sw_vref", int'(sw_vref), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_result", int'(result_bcd), 0);
        checkOutput("rst_neg", int'(result_neg), 0);
        checkOutput("rst_ovr", int'(overrange), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 7; t++) begin
            applyStimulus(vecs[t].zero_at, vecs[t].pol, 1'b1, 1'b0, 1'b0, gb, gn, go);
            checkOutput($sformatf("vec%0d_bcd", t), gb, int'(vecs[t].exp_bcd));
            checkOutput($sformatf("vec%0d_neg", t), gn, int'(vecs[t].exp_neg));
            checkOutput($sformatf("vec%0d_ovr", t), go, int'(vecs[t].exp_ovr));
        end

        // Continuous mode: two back-to-back conversions, dropped during the second one.
        cont_mode = 1'b1;
        applyStimulus(123, 1'b0, 1'b0, 1'b0, 1'b0, gb, gn, go);
        checkOutput("cont1_bcd", gb, 12'h123);
        checkOutput("cont_no_idle", int'(busy), 1);
        applyStimulus(456, 1'b1, 1'b0, 1'b1, 1'b0, gb, gn, go);
        checkOutput("cont2_bcd", gb, 12'h456);
        checkOutput("cont2_neg", gn, 1);
        checkOutput("cont_idle_sw_az", int'(sw_az), 1);

        for (int r = 0; r < 8; r++) begin
            za = int'($urandom_range(2, 1005));
            pl = logic'($urandom_range(0, 1));
            modelResult(za, eb, eo);
            applyStimulus(za, pl, 1'b1, 1'b0, 1'b0, gb, gn, go);
            checkOutput($sformatf("rand%0d_bcd", r), gb, eb);
            checkOutput($sformatf("rand%0d_neg", r), gn, int'(pl));
            checkOutput($sformatf("rand%0d_ovr", r), go, eo);
        end

        // Reset in the middle of integrate must abort immediately.
        polarity = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        checkOutput("mid_integrate", int'(sw_vin), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_sw_az", int'(sw_az), 1);
        checkOutput("abort_sw_vin", int'(sw_vin), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_result", int'(result_bcd), 0);
        checkOutput("abort_ovr", int'(overrange), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // A second start pulse while busy must not disturb or retrigger the conversion.
        modelResult(321, eb, eo);
        applyStimulus(321, 1'b1, 1'b1, 1'b0, 1'b1, gb, gn, go);
        checkOutput("busy_start_bcd", gb, eb);
        checkOutput("busy_start_neg", gn, 1);
        repeat (3) @(negedge clk);
        checkOutput("busy_start_no_retrigger", int'(busy), 0);

`ifdef DSADC_HOLD_EN
        applyStimulus(200, 1'b0, 1'b1, 1'b0, 1'b0, gb, gn, go);
        checkOutput("hold_first_bcd", gb, 12'h200);
        hold = 1'b1;
        applyStimulus(300, 1'b1, 1'b1, 1'b0, 1'b0, gb, gn, go);
        checkOutput("hold_kept_bcd", gb, 12'h200);
        checkOutput("hold_kept_neg", gn, 0);
        hold = 1'b0;
`endif

        checkOutput("onehot_errs", onehot_errs, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
